// File: rtl/klp_step_ctrl.sv
// klp_step_ctrl: execution-pace controller for the KLP32V1 core.
// Issues a one-cycle clock-enable pulse either from a free-running
// prescaler (run mode) or from a debounced push-button press (step mode),
// counts issued pulses and latches a sticky halt request.
module klp_step_ctrl #(
  parameter int DIV             = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_step_btn_n,
  input  logic        i_run_mode,
  input  logic        i_halt,
  output logic        o_cpu_en,
  output logic        o_running,
  output logic        o_halted,
  output logic [31:0] o_step_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0]  PS_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  logic           btn_s1_q, btn_s2_q;
  logic           run_s1_q, run_s2_q;
  logic           db_q, db_d, db_prev_q;
  logic [DBW-1:0] dbc_q, dbc_d;
  logic           step_req;
  state_t         state_q, state_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic           en_q, en_d;
  logic           running_q, halted_q;
  logic [31:0]    cnt_q;

  // Two-flop synchronizers for the asynchronous button and mode switch
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= i_step_btn_n;
      btn_s2_q <= btn_s1_q;
      run_s1_q <= i_run_mode;
      run_s2_q <= run_s1_q;
    end
  end

  // Debounce: count consecutive samples that differ from the accepted level;
  // once the count reaches the threshold the new level is taken
  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    if (dbc_q == DB_MAX) begin
      db_d  = btn_s2_q;
      dbc_d = '0;
    end else if (btn_s2_q != db_q) begin
      dbc_d = dbc_q + DBW'(1);
    end else begin
      dbc_d = '0;
    end
  end

  // Debounced level, its delayed copy for edge detect, and the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      dbc_q     <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbc_q     <= dbc_d;
    end
  end

  // Press only (released -> pressed); release is ignored
  assign step_req = db_prev_q & ~db_q;

  // Next state and pulse decision: halt beats mode change beats pulse
  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    en_d    = 1'b0;
    case (state_q)
      ST_STEP: begin
        if (i_halt)        state_d = ST_HALT;
        else if (run_s2_q) state_d = ST_RUN;
        else               en_d    = step_req;
      end
      ST_RUN: begin
        if (i_halt)         state_d = ST_HALT;
        else if (!run_s2_q) state_d = ST_STEP;
        else if (pre_q == PS_MAX) en_d = 1'b1;
        else                pre_d = pre_q + PW'(1);
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_STEP;
    endcase
  end

  // State, prescaler, registered enable and registered state decodes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STEP;
      pre_q     <= '0;
      en_q      <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      en_q      <= en_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  // Issued-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + {31'd0, en_q};
  end

  assign o_cpu_en     = en_q;
  assign o_running    = running_q;
  assign o_halted     = halted_q;
  assign o_step_count = cnt_q;

endmodule

// File: doc/klp_step_ctrl.md
# klp_step_ctrl

Execution-pace controller that sits directly upstream of the KLP32V1 processor core on the DE10-Lite board. It produces the single-cycle clock-enable pulse that advances the core by one instruction, from either a free-running prescaler (run mode) or a debounced, edge-detected push button (single-step mode). It also counts the instructions issued and supports a sticky halt request. This lets the core run on the board clock with no derived clock.

## Interface
- DIV, default 50_000_000: prescaler period in clk cycles per enable pulse in run mode; legal range ≥ 2.
- DEBOUNCE_CYCLES, default 500_000: consecutive stable synchronized samples required to accept a button level change; legal range ≥ 1.
- clk  input  1  board clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_step_btn_n  input  1  raw step push button, asynchronous; low = pressed.
- i_run_mode  input  1  raw slide switch, asynchronous; 1 = run mode, 0 = single-step mode.
- i_halt  input  1  synchronous halt request from the core (e.g. ebreak decode); level-sampled.
- o_cpu_en  output  1  one-clk-wide enable pulse; the core advances exactly one instruction per high cycle.
- o_running  output  1  high while the FSM is in RUN.
- o_halted  output  1  high while the FSM is in HALT.
- o_step_count  output  32  count of o_cpu_en pulses issued since reset.

## Operation
- **Synchronizers**
  - Two-flop synchronizer on i_step_btn_n, with reset value 1.
  - Two-flop synchronizer on i_run_mode, with reset value 0.
- **Debouncer**
  - btn_db reset value is 1 (released). Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
  - When the synchronized button differs from btn_db, the counter increments. Otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES, btn_db takes the synchronized value and the counter clears.
  - Any bounce back to the btn_db value before the threshold clears the counter.
- **Press detect**
  - step_req is a one-cycle pulse on a btn_db 1→0 transition.
  - Release (0→1) generates nothing.
- **FSM states:** STEP (reset state), RUN, HALT.
- **STEP**
  - o_cpu_en = step_req.
  - Go to RUN when run_sync = 1.
- **RUN**
  - The prescaler counts 0..DIV-1.
  - o_cpu_en is asserted in the cycle the count equals DIV-1; the count then wraps to 0.
  - step_req is ignored.
  - Go to STEP when run_sync = 0. The prescaler clears to 0 and no pulse is issued in the transition cycle.
  - On entry from STEP the prescaler starts at 0.
- **HALT**
  - Entered from STEP or RUN whenever i_halt = 1.
  - o_cpu_en = 0 and the prescaler is held at 0.
  - HALT is sticky: it exits only via reset, to STEP.
- **Priority within one cycle:** reset > i_halt > mode change > pulse generation.
  - A pulse that would coincide with i_halt = 1 is suppressed and not counted.
- **o_step_count**
  - Increments by 1 in the cycle after each o_cpu_en high cycle.
  - Wraps from 0xFFFF_FFFF to 0; no saturation.
- o_running = (state == RUN); o_halted = (state == HALT). Both are registered state decodes.

## Timing
- **Reset values:** o_cpu_en = 0, o_running = 0, o_halted = 0, o_step_count = 0, state = STEP, prescaler = 0, debounce counter = 0, btn_db = 1.
- **Reset mid-operation:** reset during RUN or HALT returns to STEP next cycle. An in-flight debounce is discarded. A button still held after reset is treated as a new press once debounced.
- **o_cpu_en is registered** and never high in two consecutive cycles, in any mode.
- **Step latency:** with i_step_btn_n low and stable from the first sampling edge E0, o_cpu_en is high for exactly one cycle, DEBOUNCE_CYCLES + 3 edges after E0. This is 2 synchronizer edges plus the debounce threshold plus 1 register stage.
- **Run cadence:** the first pulse comes DIV cycles after the FSM enters RUN. After that, pulses are exactly DIV cycles apart.
- **Mode switch latency:** 2 cycles of synchronizer, plus 1 cycle to register the state.
- **i_halt latency:** sampled directly. o_halted is high the cycle after i_halt is seen. o_cpu_en is 0 in the cycle i_halt is high.
- **Held button:** holding the button produces exactly one pulse per debounced press, never repeated.

## Test plan
Parameters for all tests: DIV = 4, DEBOUNCE_CYCLES = 3.
- **Reset:** assert reset 3 cycles with random inputs → all outputs 0 and state STEP; deassert with button released → no pulses for 20 cycles.
- **Debounced step:** drop i_step_btn_n and hold 10 cycles → exactly one o_cpu_en pulse, 6 edges after the first low sample; o_step_count = 1. Then toggle the button 0/1/0 every cycle for 10 cycles → no additional pulse.
- **Run cadence:** set i_run_mode = 1 → o_running high 3 cycles later; pulses every 4 cycles; after 5 pulses o_step_count = 5. Pressing the button during RUN adds none.
- **Mode exit mid-count:** in RUN, drop i_run_mode 2 cycles after a pulse → return to STEP, no further pulses. Re-enter RUN → first pulse exactly 4 cycles after o_running rises.
- **Halt priority:** assert i_halt in the same cycle a RUN pulse is due → o_cpu_en stays 0 and o_step_count is unchanged; o_halted is high next cycle. It stays halted after i_halt drops and across a button press, until reset.
- **Counter wrap:** force o_step_count to 0xFFFF_FFFF, issue one step → o_step_count = 0.
